// File: rtl/cache_port_arbiter_pkg.sv
// Shared constants and types for the data-cache port arbiter: state encoding,
// requester indices, default limits and the latched request record.
package cache_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic REQ_STG1 = 1'b0;
  localparam logic REQ_AUX  = 1'b1;

  localparam int unsigned DEF_STARVE_LIMIT = 4;
  localparam int unsigned DEF_TIMEOUT      = 31;

  typedef struct packed {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
  } req_fields_t;

  typedef struct packed {
    logic [1:0] state;
    logic [3:0] starve_cnt;
    logic [5:0] tmo_cnt;
    logic       owner;
  } arb_dbg_t;

  function automatic req_fields_t pick_fields(input logic sel,
                                              input req_fields_t f0,
                                              input req_fields_t f1);
    return sel ? f1 : f0;
  endfunction

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Requester and cache-port signal bundle for cache_port_arbiter.
// Handshake: a requester holds req high with stable rw/addr/wdata until it sees
// its one-cycle gnt; the access then completes with a one-cycle done (and err on
// timeout). On the cache side, ch_en stays high with stable fields until ch_hit.
interface cache_port_arbiter_if;
  logic       req0, req1;
  logic       rw0, rw1;
  logic [7:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1;
  logic       done0, done1;
  logic       err0, err1;
  logic [7:0] rdata;
  logic       ch_en;
  logic       ch_rw;
  logic [7:0] ch_addr;
  logic [7:0] ch_wdata;
  logic [7:0] ch_rdata;
  logic       ch_hit;
  logic       busy;

  modport master (
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, ch_rdata, ch_hit,
    output gnt0, gnt1, done0, done1, err0, err1, rdata,
           ch_en, ch_rw, ch_addr, ch_wdata, busy
  );

  modport slave (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, ch_rdata, ch_hit,
    input  gnt0, gnt1, done0, done1, err0, err1, rdata,
           ch_en, ch_rw, ch_addr, ch_wdata, busy
  );
endinterface

// File: rtl/cache_port_arbiter_starve.sv
// Two-way priority pick (stage-1 first) with a saturating loss counter that
// hands the auxiliary master the next arbitration once it has lost enough.
module arb_starve_guard
  import cache_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       arb_en_i,
  input  logic       req0_i,
  input  logic       req1_i,
  output logic       win_o,
  output logic       valid_o,
  output logic [3:0] starve_cnt_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    valid_o = req0_i | req1_i;
    win_o   = REQ_STG1;
    if (req1_i && (!req0_i || (starve_cnt_q == LIMIT))) win_o = REQ_AUX;
  end

  // Only IDLE cycles count: a loss is an arbitration where req1 was up but 0 won.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (arb_en_i) begin
      if (!req1_i || (win_o == REQ_AUX)) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != LIMIT) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end

  assign starve_cnt_o = starve_cnt_q;

endmodule

// File: rtl/cache_port_arbiter.sv
// Sequencer for the single data-cache port: grants one requester, holds the
// cache access until ch_hit or timeout, then returns done/err and read data.
module cache_port_arbiter
  import cache_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                   g_clk,
  input  logic                   g_clr,
  cache_port_arbiter_if.master   bus,
  output arb_dbg_t               dbg_o
);

  localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic [5:0] tmo_q, tmo_d;
  logic       gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic       done0_q, done0_d, done1_q, done1_d;
  logic       err0_q, err0_d, err1_q, err1_d;
  logic [7:0] rdata_q, rdata_d;
  logic       ch_en_q, ch_en_d;
  logic       ch_rw_q, ch_rw_d;
  logic [7:0] ch_addr_q, ch_addr_d;
  logic [7:0] ch_wdata_q, ch_wdata_d;
  logic       busy_q, busy_d;

  logic        arb_en;
  logic        arb_win;
  logic        arb_valid;
  logic [3:0]  starve_cnt;
  req_fields_t f0, f1, win_fields;
  logic        finish;
  logic        finish_err;

  assign arb_en = (state_q == ST_IDLE);
  assign f0     = '{rw: bus.rw0, addr: bus.addr0, wdata: bus.wdata0};
  assign f1     = '{rw: bus.rw1, addr: bus.addr1, wdata: bus.wdata1};

  arb_starve_guard #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_guard (
    .clk_i        (g_clk),
    .rst_i        (g_clr),
    .arb_en_i     (arb_en),
    .req0_i       (bus.req0),
    .req1_i       (bus.req1),
    .win_o        (arb_win),
    .valid_o      (arb_valid),
    .starve_cnt_o (starve_cnt)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    tmo_d      = tmo_q;
    rdata_d    = rdata_q;
    ch_en_d    = ch_en_q;
    ch_rw_d    = ch_rw_q;
    ch_addr_d  = ch_addr_q;
    ch_wdata_d = ch_wdata_q;
    busy_d     = busy_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
    win_fields = '0;
    finish     = 1'b0;
    finish_err = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          // The ch_* registers double as the owner's latched request fields.
          win_fields = pick_fields(arb_win, f0, f1);
          ch_rw_d    = win_fields.rw;
          ch_addr_d  = win_fields.addr;
          ch_wdata_d = win_fields.wdata;
          owner_d    = arb_win;
          tmo_d      = '0;
          gnt0_d     = (arb_win == REQ_STG1);
          gnt1_d     = (arb_win == REQ_AUX);
          ch_en_d    = 1'b1;
          busy_d     = 1'b1;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        tmo_d = tmo_q + 6'd1;
        // Hit is checked first so a hit on the last allowed cycle is not an error.
        if (bus.ch_hit) begin
          finish = 1'b1;
          if (!ch_rw_q) rdata_d = bus.ch_rdata;
        end else if (tmo_q == TMO_LAST) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end
        if (finish) begin
          ch_en_d = 1'b0;
          state_d = ST_DONE;
          done0_d = (owner_q == REQ_STG1);
          done1_d = (owner_q == REQ_AUX);
          err0_d  = finish_err && (owner_q == REQ_STG1);
          err1_d  = finish_err && (owner_q == REQ_AUX);
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        ch_en_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      state_q    <= ST_IDLE;
      owner_q    <= REQ_STG1;
      tmo_q      <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rdata_q    <= '0;
      ch_en_q    <= 1'b0;
      ch_rw_q    <= 1'b0;
      ch_addr_q  <= '0;
      ch_wdata_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      tmo_q      <= tmo_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
      rdata_q    <= rdata_d;
      ch_en_q    <= ch_en_d;
      ch_rw_q    <= ch_rw_d;
      ch_addr_q  <= ch_addr_d;
      ch_wdata_q <= ch_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.err0     = err0_q;
  assign bus.err1     = err1_q;
  assign bus.rdata    = rdata_q;
  assign bus.ch_en    = ch_en_q;
  assign bus.ch_rw    = ch_rw_q;
  assign bus.ch_addr  = ch_addr_q;
  assign bus.ch_wdata = ch_wdata_q;
  assign bus.busy     = busy_q;

  assign dbg_o = '{state: state_q, starve_cnt: starve_cnt, tmo_cnt: tmo_q, owner: owner_q};

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter: vector table of single accesses,
// then starvation, hit-outside-BUSY and mid-access reset sequences.
module tb_cache_port_arbiter;
  import cache_port_arbiter_pkg::*;

  localparam int TMO    = 31;
  localparam int STARVE = 4;
  localparam int NVEC   = 10;

  typedef struct {
    logic       who;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         hit_at;     // BUSY cycle (1-based) that sees ch_hit; 0 = never
    logic [7:0] cdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_cycles;
  } vec_t;

  logic     g_clk = 1'b0;
  logic     g_clr;
  arb_dbg_t dbg;

  cache_port_arbiter_if bus ();

  cache_port_arbiter #(
    .STARVE_LIMIT (STARVE),
    .TIMEOUT      (TMO)
  ) dut (
    .g_clk (g_clk),
    .g_clr (g_clr),
    .bus   (bus),
    .dbg_o (dbg)
  );

  always #5 g_clk = ~g_clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] exp_q[$];
  logic [7:0] model_rdata;
  vec_t       vecs[NVEC];
  logic       exp_order[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic drive_req(input vec_t v);
    if (v.who == REQ_STG1) begin
      bus.req0 = 1'b1; bus.rw0 = v.rw; bus.addr0 = v.addr; bus.wdata0 = v.wdata;
    end else begin
      bus.req1 = 1'b1; bus.rw1 = v.rw; bus.addr1 = v.addr; bus.wdata1 = v.wdata;
    end
  endtask

  task automatic check_done(input string tag, input logic who);
    logic [8:0] e;
    logic [1:0] sel;
    sel = (who == REQ_AUX) ? 2'b10 : 2'b01;
    check({tag, "_done"}, {bus.done1, bus.done0}, sel);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_err"}, {bus.err1, bus.err0}, e[8] ? sel : 2'b00);
      check({tag, "_rdata"}, bus.rdata, e[7:0]);
    end
  endtask

  task automatic run_access(input vec_t v);
    int   cyc;
    logic held_ok;
    drive_req(v);
    exp_q.push_back({v.exp_err, v.exp_rdata});
    step();
    check("gnt", {bus.gnt1, bus.gnt0}, (v.who == REQ_AUX) ? 2'b10 : 2'b01);
    check("ch_en_at_gnt", bus.ch_en, 1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    cyc     = 0;
    held_ok = 1'b1;
    while (bus.ch_en === 1'b1 && cyc < 100) begin
      cyc++;
      if (bus.ch_rw !== v.rw || bus.ch_addr !== v.addr || bus.ch_wdata !== v.wdata)
        held_ok = 1'b0;
      bus.ch_hit   = (cyc == v.hit_at);
      bus.ch_rdata = (cyc == v.hit_at) ? v.cdata : ~v.cdata;
      step();
    end
    bus.ch_hit = 1'b0;
    check("ch_fields_held", held_ok, 1);
    check("ch_en_cycles", cyc, v.exp_cycles);
    check("busy_in_done", bus.busy, 1);
    check_done("acc", v.who);
    step();
    check("done_cleared", {bus.done1, bus.done0, bus.err1, bus.err0}, 0);
    check("busy_after", bus.busy, 0);
    check("state_idle", dbg.state, ST_IDLE);
  endtask

  task automatic set_vec(input int i, input logic who, input logic rw, input logic [7:0] addr,
                         input logic [7:0] wdata, input int hit_at, input logic [7:0] cdata);
    vecs[i].who    = who;
    vecs[i].rw     = rw;
    vecs[i].addr   = addr;
    vecs[i].wdata  = wdata;
    vecs[i].hit_at = hit_at;
    vecs[i].cdata  = cdata;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t rv;
    logic [7:0] m;
    g_clr = 1'b1;
    bus.req0 = 0; bus.req1 = 0; bus.rw0 = 0; bus.rw1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    bus.ch_rdata = 0; bus.ch_hit = 0;

    // Vector table: fixed corner cases followed by randomized short accesses.
    set_vec(0, REQ_STG1, 1'b0, 8'h05, 8'h00, 1,  8'hA7);
    set_vec(1, REQ_AUX,  1'b1, 8'h0C, 8'h3F, 6,  8'h11);
    set_vec(2, REQ_STG1, 1'b0, 8'h10, 8'h00, 0,  8'h99);
    set_vec(3, REQ_AUX,  1'b0, 8'h22, 8'h00, 31, 8'h5C);
    set_vec(4, REQ_STG1, 1'b1, 8'hFF, 8'h81, 30, 8'h42);
    set_vec(5, REQ_AUX,  1'b0, 8'h00, 8'h00, 2,  8'h3C);
    for (int i = 6; i < NVEC; i++)
      set_vec(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), $urandom_range(1, 8), 8'($urandom_range(0, 255)));
    m = 8'h00;
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].hit_at == 0 || vecs[i].hit_at > TMO) begin
        vecs[i].exp_err    = 1'b1;
        vecs[i].exp_cycles = TMO;
      end else begin
        vecs[i].exp_err    = 1'b0;
        vecs[i].exp_cycles = vecs[i].hit_at;
        if (!vecs[i].rw) m = vecs[i].cdata;
      end
      vecs[i].exp_rdata = m;
    end
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (3) step();
    g_clr = 1'b0;
    check("rst_gnt_done_err", {bus.gnt1, bus.gnt0, bus.done1, bus.done0, bus.err1, bus.err0}, 0);
    check("rst_ch_en", bus.ch_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_ch_fields", {bus.ch_rw, bus.ch_addr, bus.ch_wdata}, 0);
    check("rst_state", dbg.state, ST_IDLE);
    check("rst_starve", dbg.starve_cnt, 0);
    check("rst_tmo", dbg.tmo_cnt, 0);

    for (int i = 0; i < NVEC; i++) run_access(vecs[i]);
    model_rdata = m;

    // ch_hit outside BUSY must not start anything or touch rdata
    bus.ch_hit = 1'b1;
    bus.ch_rdata = ~model_rdata;
    step();
    check("stray_hit_busy", bus.busy, 0);
    check("stray_hit_done", {bus.done1, bus.done0}, 0);
    check("stray_hit_rdata", bus.rdata, model_rdata);
    bus.ch_hit = 1'b0;
    step();

    // Both requesters held high: starvation guard ordering and 3-cycle spacing
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 8'h40; bus.wdata0 = 8'h00;
    bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.addr1 = 8'h80; bus.wdata1 = 8'h00;
    for (int g = 0; g < 10; g++) begin
      int k;
      logic who;
      k = 0;
      do begin
        step();
        k++;
      end while (bus.gnt0 !== 1'b1 && bus.gnt1 !== 1'b1 && k < 10);
      if (bus.gnt0 !== 1'b1 && bus.gnt1 !== 1'b1) begin
        check("starve_grant_seen", 0, 1);
        break;
      end
      who = bus.gnt1;
      check("starve_order", who, exp_order[g]);
      if (g > 0) check("grant_spacing", k + 1, 3);
      model_rdata = 8'hC0 + 8'(g);
      exp_q.push_back({1'b0, model_rdata});
      bus.ch_hit = 1'b1;
      bus.ch_rdata = model_rdata;
      step();
      bus.ch_hit = 1'b0;
      check_done("starve", who);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();

    // Reset in the 3rd BUSY cycle while req1 had just lost an arbitration
    bus.req0 = 1'b1; bus.addr0 = 8'h33; bus.rw0 = 1'b0;
    bus.req1 = 1'b1; bus.addr1 = 8'h44; bus.rw1 = 1'b1;
    step();
    check("clr_gnt0", {bus.gnt1, bus.gnt0}, 2'b01);
    check("clr_starve_before", dbg.starve_cnt, 1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();
    step();
    check("clr_third_busy", bus.ch_en, 1);
    g_clr = 1'b1;
    step();
    g_clr = 1'b0;
    check("clr_ch_en", bus.ch_en, 0);
    check("clr_busy", bus.busy, 0);
    check("clr_no_done", {bus.done1, bus.done0, bus.err1, bus.err0}, 0);
    check("clr_starve", dbg.starve_cnt, 0);
    check("clr_rdata", bus.rdata, 0);
    step();
    check("clr_no_late_done", {bus.done1, bus.done0, bus.err1, bus.err0}, 0);
    rv = '{who: REQ_AUX, rw: 1'b1, addr: 8'h5A, wdata: 8'hE1, hit_at: 2, cdata: 8'h77,
           exp_rdata: 8'h00, exp_err: 1'b0, exp_cycles: 2};
    run_access(rv);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Two-requester arbiter and sequencer for the single data-cache port (enable, rw, address, write data, read data, hit). Requester 0 is the stage-1 pipeline controller; requester 1 is an auxiliary master (I/O transfer engine or debug loader). The block latches one request at a time and drives the cache port until the cache reports completion. It then returns read data with a done pulse, or an error pulse if completion does not arrive in time. Stage-1 has priority, and a starvation guard guarantees the auxiliary master progress.

## Interface
- STARVE_LIMIT, 4: consecutive arbitration losses of requester 1 (while requesting) after which requester 1 wins the next arbitration; range 1-15.
- TIMEOUT, 31: maximum BUSY cycles without ch_hit before the access aborts; range 1-63.
- g_clk  in  1  single clock, rising edge.
- g_clr  in  1  reset, synchronous, active-high.
- req0, req1  in  1  access request, level.
- rw0, rw1  in  1  1 = write, 0 = read.
- addr0, addr1  in  8  data address.
- wdata0, wdata1  in  8  write data.
- gnt0, gnt1  out  1  one-cycle grant pulse; request fields are captured at this point.
- done0, done1  out  1  one-cycle completion pulse.
- err0, err1  out  1  one-cycle timeout pulse, coincident with done.
- rdata  out  8  read data, valid while done is high; holds its value otherwise.
- ch_en  out  1  cache enable.
- ch_rw  out  1  cache rw.
- ch_addr  out  8  cache address.
- ch_wdata  out  8  cache write data.
- ch_rdata  in  8  cache read data.
- ch_hit  in  1  access complete, including after miss fill.
- busy  out  1  high in BUSY and DONE.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE
  - req0/req1 are sampled only in IDLE.
  - Winner rule:
    - req1 alone → 1.
    - req0 alone → 0.
    - Both requesting → 0, unless starve_cnt == STARVE_LIMIT, in which case 1.
  - On any winner: latch the winner's rw/addr/wdata into owner regs, record owner, clear tmo_cnt, pulse gnt(owner), go BUSY.
- BUSY
  - Drive ch_en=1 and ch_rw/ch_addr/ch_wdata from the latched regs; tmo_cnt increments each cycle.
  - ch_hit=1 → capture ch_rdata into rdata (reads only; writes leave rdata unchanged), go DONE.
  - ch_hit=0 and tmo_cnt == TIMEOUT-1 → set the error flag, go DONE.
- DONE
  - ch_en=0; pulse done(owner), plus err(owner) if flagged; clear flag; go IDLE.
  - This is a mandatory one-cycle turnaround between accesses.
- starve_cnt (4 bits)
  - Increments on each IDLE arbitration where req1 is high and 0 wins.
  - Clears when 1 is granted, or in any IDLE cycle with req1 low.
  - Saturates at STARVE_LIMIT.
- Requester contract:
  - Fields stay stable while req is high until gnt.
  - Requester may drop req after gnt.
  - req still high in the IDLE after done is treated as a new request.
- ch_hit outside BUSY is ignored.
- ch_rw/ch_addr/ch_wdata hold their last values when ch_en=0.

## Timing
- Reset values:
  - state=IDLE; starve_cnt=0; tmo_cnt=0.
  - All gnt/done/err = 0; ch_en=0; busy=0.
  - rdata, ch_rw, ch_addr, ch_wdata = 0.
- g_clr mid-access:
  - Next state is IDLE and pending done/err are dropped.
  - The cache sees ch_en fall on the following edge.
- req sampled high at edge k → gnt and ch_en high in cycle k..k+1.
- Hit in the first BUSY cycle → done in the next cycle, IDLE after that. Minimum 3 cycles from grant to next grant.
- Timeout: err/done asserted the cycle after TIMEOUT BUSY cycles have elapsed without ch_hit.
- Simultaneous ch_hit and timeout count reached: hit wins, no err.
- All outputs are registered, with no combinational path from req to gnt or from ch_hit to done.

## Structure
- Shared package holds:
  - State encoding constants: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Requester index constants: REQ_STG1=1'b0, REQ_AUX=1'b1.
  - Default STARVE_LIMIT and TIMEOUT.
- One natural sub-module, arb_starve_guard: the 2-way priority pick plus the saturating starve_cnt. Its outputs are the winner and a valid flag. Everything else lives in the top FSM.

## Test plan
- req0 read addr=8'h05, ch_hit returned in the first BUSY cycle with ch_rdata=8'hA7 → gnt0 in cycle 1, ch_en cycle 1 only, done0 with rdata=8'hA7 in cycle 2, busy low in cycle 3.
- req1 write addr=8'h0C wdata=8'h3F, hit after 6 cycles (miss fill) → ch_rw=1, ch_addr=8'h0C, ch_wdata=8'h3F held for 6 cycles; done1 once; rdata unchanged.
- req0 and req1 both held high continuously, hits immediate, STARVE_LIMIT=4 → grant order 0,0,0,0,1,0,0,0,0,1.
- No ch_hit with TIMEOUT=31 → ch_en high exactly 31 cycles, then done0=err0=1 for one cycle, then IDLE.
- Cases where ch_hit coincides with the final timeout cycle → done without err.
- g_clr asserted in the 3rd BUSY cycle → next cycle ch_en=0, no done, starve_cnt=0. A fresh req1 is then granted with normal latency.
